// File: rtl/qlearn_pkg.sv
// ============================================================================
// Module      : qlearn_pkg
// Description : Shared constants, types and FSM encoding for the maze
//               Q-learning datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qlearn_pkg;

  // Maze geometry and value widths
  localparam int N_STATES   = 36;
  localparam int N_ACTIONS  = 4;
  localparam int Q_W        = 32;
  localparam int R_W        = 4;
  localparam int S_W        = $clog2(N_STATES);
  localparam int A_W        = $clog2(N_ACTIONS);

  // Reward issued on a goal transition and the two goal (state, action) pairs
  localparam int REWARD_VAL = 10;
  localparam int GOAL_S0    = 35;
  localparam int GOAL_A0    = 1;
  localparam int GOAL_S1    = 30;
  localparam int GOAL_A1    = 0;

  // Exploration LFSR: 16-bit Galois, taps 16,14,13,11
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic signed [Q_W-1:0] q_val_t;
  typedef logic [S_W-1:0]        state_t;
  typedef logic [A_W-1:0]        action_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } maxq_state_e;

endpackage

`default_nettype wire

// File: rtl/qlearn_lfsr16.sv
// ============================================================================
// Module      : qlearn_lfsr16
// Description : 16-bit Galois LFSR (mask 16'hB400) that advances one step per
//               enable pulse; shared by the exploration/policy stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qlearn_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_step,
  output logic [15:0] o_state
);
  import qlearn_pkg::*;

  logic [15:0] r_lfsr;
  logic [15:0] w_next;

  // Galois step: shift right, fold the dropped bit back through the taps
  always_comb begin
    w_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
  end

  // State register; reloads the seed on reset, advances only when stepped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (i_step) begin
      r_lfsr <= w_next;
    end
  end

  assign o_state = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/maxq_reward_seq.sv
// ============================================================================
// Module      : maxq_reward_seq
// Description : Sequential max-Q / argmax / reward stage. Scans one Q row from
//               RAM (one action per cycle), picks the greedy or exploratory
//               action and returns {max_q, action, reward, err} over
//               valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxq_reward_seq #(
  parameter int          N_STATES   = qlearn_pkg::N_STATES,
  parameter int          N_ACTIONS  = qlearn_pkg::N_ACTIONS,
  parameter int          Q_W        = qlearn_pkg::Q_W,
  parameter int          R_W        = qlearn_pkg::R_W,
  parameter int          REWARD_VAL = qlearn_pkg::REWARD_VAL,
  parameter int          GOAL_S0    = qlearn_pkg::GOAL_S0,
  parameter int          GOAL_A0    = qlearn_pkg::GOAL_A0,
  parameter int          GOAL_S1    = qlearn_pkg::GOAL_S1,
  parameter int          GOAL_A1    = qlearn_pkg::GOAL_A1,
  parameter logic [15:0] LFSR_SEED  = qlearn_pkg::LFSR_SEED,
  localparam int         S_W        = $clog2(N_STATES),
  localparam int         A_W        = $clog2(N_ACTIONS),
  localparam int         ADDR_W     = $clog2(N_STATES*N_ACTIONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [S_W-1:0]        in_state,
  input  logic                  in_explore,
  output logic                  q_rd_en,
  output logic [ADDR_W-1:0]     q_rd_addr,
  input  logic signed [Q_W-1:0] q_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Q_W-1:0] max_q,
  output logic [A_W-1:0]        action,
  output logic [R_W-1:0]        reward,
  output logic                  err
);
  import qlearn_pkg::*;

  // One extra bit so a power-of-two N_STATES still fits the range bound
  localparam logic [S_W:0] C_NS = (S_W+1)'(N_STATES);

  maxq_state_e           r_fsm;
  logic [S_W-1:0]        r_state;
  logic                  r_explore;
  logic [A_W-1:0]        r_iss_idx;
  logic [A_W-1:0]        r_rx_idx;
  logic                  r_rd_vld;
  logic signed [Q_W-1:0] r_run_max;
  logic [A_W-1:0]        r_run_arg;

  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_rd_en;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic signed [Q_W-1:0] r_max_q;
  logic [A_W-1:0]        r_action;
  logic [R_W-1:0]        r_reward;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_in_range;
  logic [S_W+A_W-1:0]    w_row_base;
  logic [15:0]           w_lfsr;
  logic                  w_take;
  logic signed [Q_W-1:0] w_fin_max;
  logic [A_W-1:0]        w_fin_arg;
  logic [A_W-1:0]        w_act;
  logic                  w_goal;

  assign w_accept = in_valid && r_in_ready;

  // The LFSR steps on every accepted request and then holds, so its state
  // during the scan is exactly the value sampled at accept.
  qlearn_lfsr16 #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_step  (w_accept),
    .o_state (w_lfsr)
  );

  // Request decode and running-max merge of the word arriving this cycle
  always_comb begin
    w_in_range = {1'b0, in_state} < C_NS;
    w_row_base = {in_state, {A_W{1'b0}}};
    // First word always loads; later words only win if strictly greater,
    // which keeps ties on the lowest action index.
    w_take     = r_rd_vld && ((r_rx_idx == '0) || (q_rd_data > r_run_max));
    w_fin_max  = w_take ? q_rd_data : r_run_max;
    w_fin_arg  = w_take ? r_rx_idx  : r_run_arg;
    w_act      = r_explore ? w_lfsr[A_W-1:0] : w_fin_arg;
    w_goal     = ((r_state == S_W'(GOAL_S0)) && (w_act == A_W'(GOAL_A0))) ||
                 ((r_state == S_W'(GOAL_S1)) && (w_act == A_W'(GOAL_A1)));
  end

  // Control FSM with registered handshake, RAM strobe and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_explore   <= 1'b0;
      r_iss_idx   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_max_q     <= '0;
      r_action    <= '0;
      r_reward    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state    <= in_state;
            r_explore  <= in_explore;
            r_iss_idx  <= '0;
            r_in_ready <= 1'b0;
            if (w_in_range) begin
              r_fsm     <= ISSUE;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_row_base[ADDR_W-1:0];
            end else begin
              // Out-of-range state: answer immediately, never touch the RAM
              r_fsm       <= DONE;
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
              r_max_q     <= '0;
              r_action    <= '0;
              r_reward    <= '0;
            end
          end
        end
        ISSUE: begin
          if (r_iss_idx == A_W'(N_ACTIONS-1)) begin
            r_rd_en <= 1'b0;
            r_fsm   <= DRAIN;
          end else begin
            r_iss_idx <= r_iss_idx + A_W'(1);
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Last word of the row is on q_rd_data now; fold it in directly
          r_fsm       <= DONE;
          r_out_valid <= 1'b1;
          r_err       <= 1'b0;
          r_max_q     <= w_fin_max;
          r_action    <= w_act;
          r_reward    <= w_goal ? R_W'(REWARD_VAL) : '0;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  // Running max/argmax over returning read words, restarted on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rx_idx  <= '0;
      r_run_max <= '0;
      r_run_arg <= '0;
    end else begin
      r_rd_vld <= r_rd_en;
      if (w_accept) begin
        r_rx_idx  <= '0;
        r_run_max <= '0;
        r_run_arg <= '0;
      end else if (r_rd_vld) begin
        r_rx_idx  <= r_rx_idx + A_W'(1);
        r_run_max <= w_fin_max;
        r_run_arg <= w_fin_arg;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q_rd_en   = r_rd_en;
  assign q_rd_addr = r_rd_addr;
  assign max_q     = r_max_q;
  assign action    = r_action;
  assign reward    = r_reward;
  assign err       = r_err;

endmodule

`default_nettype wire
